inst_mem_loader: RTL and testbench

Writer-side companion to the instruction memory. It receives a program one W-bit word at a time over a valid/ready stream and assembles the flat N*W-bit image that the instruction memory latches. Once the image is complete, it issues a one-cycle load strobe that the instruction memory uses as its latch/reset input. It sits between the host/garbling-input deserializer and the MIPS instruction memory.

---
 rtl/inst_mem_loader.sv | 82 ++++++++
 tb/tb_inst_mem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Assembles a flat N*W-bit instruction image from a valid/ready word stream,
// then strobes load_pulse_o once so the instruction memory latches it.
module inst_mem_loader #(
  parameter int W = 32,
  parameter int L = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [(2**L)*W-1:0] image_o,
  output logic             load_pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [L:0]       word_count_o
);

  localparam int N = 2 ** L;
  localparam logic [L:0] LAST_IDX = (L+1)'(N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [N*W-1:0] image_q, image_d;
  logic [L:0]     count_q, count_d;

  always_comb begin
    state_d = state_q;
    image_d = image_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_FILL;
          image_d = '0;
          count_d = '0;
        end
      end
      S_FILL: begin
        // in_ready is implied by being in FILL, so in_valid alone is a handshake
        if (in_valid_i) begin
          image_d[count_q[L-1:0]*W +: W] = in_data_i;
          count_d = count_q + 1'b1;
          if (in_last_i || (count_q == LAST_IDX)) begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      image_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      image_q <= image_d;
      count_q <= count_d;
    end
  end

  // Strobe and status are pure state decodes, so reset clears them asynchronously.
  assign in_ready_o   = (state_q == S_FILL);
  assign load_pulse_o = (state_q == S_COMMIT);
  assign busy_o       = (state_q == S_FILL) || (state_q == S_SETTLE) || (state_q == S_COMMIT);
  assign done_o       = (state_q == S_DONE);
  assign image_o      = image_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: accepted words are queued as they are
// driven and drained into an expected image when the load strobe appears.
module tb_inst_mem_loader;

  localparam int W = 32;
  localparam int L = 6;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] image;
  logic           load_pulse;
  logic           busy;
  logic           done;
  logic [L:0]     word_count;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [W-1:0] sb[$];

  inst_mem_loader #(.W(W), .L(L)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .in_valid_i(in_valid),
    .in_data_i(in_data),
    .in_last_i(in_last),
    .in_ready_o(in_ready),
    .image_o(image),
    .load_pulse_o(load_pulse),
    .busy_o(busy),
    .done_o(done),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (load_pulse === 1'b1) pulse_cnt++;
  end

  task automatic apply_reset();
    start = 0; in_valid = 0; in_last = 0; in_data = '0;
    rst_n = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    tests++;
    if (image !== '0 || word_count !== '0 || in_ready !== 1'b0 || done !== 1'b0 ||
        load_pulse !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs count=%0d ready=%b done=%b pulse=%b busy=%b image_nonzero=%b, want all 0",
               word_count, in_ready, done, load_pulse, busy, (image !== '0));
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  // One complete load: start, feed words (optionally throttled or with a stray
  // start mid-FILL), then check SETTLE, COMMIT and DONE cycle by cycle.
  task automatic run_load(input int nwords, input bit use_last, input bit throttle,
                          input bit mid_start, input logic [W-1:0] base, input string name);
    int idx = 0;
    int cyc = 0;
    int k = 0;
    int p0;
    logic [N*W-1:0] exp_img;
    start = 1; in_valid = 0; in_last = 0;
    @(negedge clk);
    start = 0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1 || word_count !== '0 || image !== '0) begin
      fails++;
      $display("[TB] FAIL %s_start busy=%b done=%b ready=%b count=%0d image_nonzero=%b, want 1 0 1 0 0",
               name, busy, done, in_ready, word_count, (image !== '0));
    end
    p0 = pulse_cnt;
    while (idx < nwords && cyc < 1000) begin
      in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = base + W'(idx);
      in_last  = use_last && (idx == nwords - 1);
      start    = mid_start && (idx == nwords / 2);
      @(negedge clk);
      cyc++;
      start = 0;
      if (in_valid) begin
        sb.push_back(in_data);
        idx++;
        tests++;
        if (word_count !== (L+1)'(idx)) begin
          fails++;
          $display("[TB] FAIL %s_count got %0d want %0d", name, word_count, idx);
        end
      end
    end
    if (cyc >= 1000) begin
      tests++; fails++;
      $display("[TB] FAIL %s_timeout accepted %0d want %0d", name, idx, nwords);
    end
    // SETTLE: keep offering junk so any write outside FILL would show up.
    in_valid = 1; in_data = 32'hBAD0_0000; in_last = 1;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || load_pulse !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_settle ready=%b busy=%b pulse=%b done=%b, want 0 1 0 0",
               name, in_ready, busy, load_pulse, done);
    end
    @(negedge clk);
    tests++;
    if (load_pulse !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_commit pulse=%b busy=%b ready=%b, want 1 1 0", name, load_pulse, busy, in_ready);
    end
    exp_img = '0;
    k = 0;
    while (sb.size() > 0) begin
      exp_img[k*W +: W] = sb.pop_front();
      k++;
    end
    tests++;
    if (image !== exp_img || word_count !== (L+1)'(k)) begin
      fails++;
      $display("[TB] FAIL %s_image count got %0d want %0d, word0 got %h want %h, word63 got %h want %h",
               name, word_count, k, image[W-1:0], exp_img[W-1:0], image[N*W-1 -: W], exp_img[N*W-1 -: W]);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || load_pulse !== 1'b0 || in_ready !== 1'b0 || image !== exp_img) begin
      fails++;
      $display("[TB] FAIL %s_done done=%b busy=%b pulse=%b ready=%b image_ok=%b, want 1 0 0 0 1",
               name, done, busy, load_pulse, in_ready, (image === exp_img));
    end
    tests++;
    if (pulse_cnt - p0 != 1) begin
      fails++;
      $display("[TB] FAIL %s_pulse_count got %0d want 1", name, pulse_cnt - p0);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    in_valid = 1; in_data = 32'hDEAD_BEEF;
    repeat (10) @(negedge clk);
    in_valid = 0;
    tests++;
    if (image !== '0 || word_count !== '0 || in_ready !== 1'b0 || done !== 1'b0 ||
        load_pulse !== 1'b0 || pulse_cnt != 0) begin
      fails++;
      $display("[TB] FAIL idle_ignores_valid count=%0d ready=%b done=%b pulses=%0d image_nonzero=%b, want all 0",
               word_count, in_ready, done, pulse_cnt, (image !== '0));
    end
  endtask

  task automatic test_full();
    run_load(N, 1'b0, 1'b0, 1'b0, 32'h1000_0000, "full");
  endtask

  task automatic test_short();
    run_load(5, 1'b1, 1'b0, 1'b0, 32'h2000_0000, "short");
  endtask

  task automatic test_throttled();
    run_load(N, 1'b0, 1'b1, 1'b0, 32'h1000_0000, "throttled");
  endtask

  task automatic test_back_to_back();
    run_load(N, 1'b1, 1'b0, 1'b1, 32'h3000_0000, "midstart");
    run_load(1, 1'b1, 1'b0, 1'b0, 32'h4000_0000, "single");
  endtask

  task automatic test_restart();
    start = 1;
    @(negedge clk);
    start = 0;
    tests++;
    if (image !== '0 || word_count !== '0 || in_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL restart count=%0d ready=%b done=%b image_nonzero=%b, want 0 1 0 0",
               word_count, in_ready, done, (image !== '0));
    end
  endtask

  task automatic test_abort();
    int p0;
    apply_reset();
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h5000_0000 + W'(i);
      @(negedge clk);
    end
    in_valid = 0;
    tests++;
    if (word_count !== (L+1)'(10)) begin
      fails++;
      $display("[TB] FAIL abort_precount got %0d want 10", word_count);
    end
    p0 = pulse_cnt;
    #2 rst_n = 0;
    #1;
    tests++;
    if (image !== '0 || word_count !== '0 || in_ready !== 1'b0 || done !== 1'b0 ||
        load_pulse !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_immediate count=%0d ready=%b done=%b pulse=%b busy=%b, want all 0",
               word_count, in_ready, done, load_pulse, busy);
    end
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_no_pulse pulses got %0d want %0d busy=%b done=%b", pulse_cnt - p0, 0, busy, done);
    end
    run_load(N, 1'b0, 1'b0, 1'b0, 32'h6000_0000, "after_abort");
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_last = 0; in_data = '0;
    test_reset();
    test_full();
    test_short();
    test_throttled();
    test_back_to_back();
    test_restart();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
